// File: rtl/cam_pkg.sv
// Shared types and default sizing for the CAM array and its entries.
package cam_pkg;

    localparam int unsigned DefaultDataWidth = 32;
    localparam int unsigned DefaultDepth     = 32;

    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_WRITE,
        CMD_ALLOC,
        CMD_INVAL,
        CMD_READ,
        CMD_SEARCH
    } cmd_e;

endpackage

// File: rtl/cam_array_if.sv
// Command and result bundle between the command decoder, the CAM and its lookup consumers.
interface cam_array_if
    import cam_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefaultDataWidth,
    parameter int unsigned IDX_WIDTH  = $clog2(DefaultDepth)
) ();

    logic                  write_i;
    logic [IDX_WIDTH-1:0]  write_index_i;
    logic [DATA_WIDTH-1:0] write_data_i;
    logic                  alloc_i;
    logic                  inval_i;
    logic [IDX_WIDTH-1:0]  inval_index_i;
    logic                  read_i;
    logic [IDX_WIDTH-1:0]  read_index_i;
    logic                  search_i;
    logic [DATA_WIDTH-1:0] search_data_i;

    logic                  read_valid_o;
    logic [DATA_WIDTH-1:0] read_value_o;
    logic                  search_valid_o;
    logic                  search_hit_o;
    logic [IDX_WIDTH-1:0]  search_index_o;
    logic [IDX_WIDTH-1:0]  alloc_index_o;
    logic [IDX_WIDTH:0]    count_o;
    logic                  full_o;
    logic                  error_o;

    modport master (
        output write_i, write_index_i, write_data_i, alloc_i, inval_i, inval_index_i,
               read_i, read_index_i, search_i, search_data_i,
        input  read_valid_o, read_value_o, search_valid_o, search_hit_o, search_index_o,
               alloc_index_o, count_o, full_o, error_o
    );

    modport slave (
        input  write_i, write_index_i, write_data_i, alloc_i, inval_i, inval_index_i,
               read_i, read_index_i, search_i, search_data_i,
        output read_valid_o, read_value_o, search_valid_o, search_hit_o, search_index_o,
               alloc_index_o, count_o, full_o, error_o
    );

endinterface

// File: rtl/cam_entry.sv
// One CAM storage cell: data word, valid bit and a live compare against the search key.
module cam_entry
    import cam_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefaultDataWidth
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we_i,
    input  logic                  clr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [DATA_WIDTH-1:0] key_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    output logic                  match_o
);

    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (we_i) begin
            data_d  = wdata_i;
            valid_d = 1'b1;
        end else if (clr_i) begin
            data_d  = '0;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    // Gating on valid keeps cleared (all-zero) slots from matching a zero key.
    assign match_o = valid_q && (key_i == data_q);

endmodule

// File: rtl/cam_array.sv
// Content-addressable memory: indexed write/read/invalidate, free-slot alloc and priority search.
module cam_array
    import cam_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = DefaultDataWidth,
    parameter  int unsigned DEPTH      = DefaultDepth,
    localparam int unsigned IDX_WIDTH  = $clog2(DEPTH)
) (
    input logic        clk,
    input logic        rst_n,
    cam_array_if.slave bus
);

    localparam logic [IDX_WIDTH:0] FullCount = (IDX_WIDTH + 1)'(DEPTH);
    localparam logic [IDX_WIDTH:0] OneCount  = (IDX_WIDTH + 1)'(1);

    cmd_e                  cmd;
    logic [2:0]            n_cmds;

    logic [DEPTH-1:0]      ent_we;
    logic [DEPTH-1:0]      ent_clr;
    logic [DEPTH-1:0]      ent_valid;
    logic [DEPTH-1:0]      ent_match;
    logic [DATA_WIDTH-1:0] ent_data [DEPTH];

    logic                  free_found;
    logic [IDX_WIDTH-1:0]  free_idx;
    logic                  match_found;
    logic [IDX_WIDTH-1:0]  match_idx;

    logic                  read_valid_q, read_valid_d;
    logic [DATA_WIDTH-1:0] read_value_q, read_value_d;
    logic                  search_valid_q, search_valid_d;
    logic                  search_hit_q, search_hit_d;
    logic [IDX_WIDTH-1:0]  search_index_q, search_index_d;
    logic [IDX_WIDTH-1:0]  alloc_index_q, alloc_index_d;
    logic [IDX_WIDTH:0]    count_q, count_d;
    logic                  full_q, full_d;
    logic                  error_q, error_d;

    always_comb begin
        cmd = CMD_NONE;
        if (bus.write_i) begin
            cmd = CMD_WRITE;
        end else if (bus.alloc_i) begin
            cmd = CMD_ALLOC;
        end else if (bus.inval_i) begin
            cmd = CMD_INVAL;
        end else if (bus.read_i) begin
            cmd = CMD_READ;
        end else if (bus.search_i) begin
            cmd = CMD_SEARCH;
        end
    end

    assign n_cmds = 3'(bus.write_i) + 3'(bus.alloc_i) + 3'(bus.inval_i)
                  + 3'(bus.read_i) + 3'(bus.search_i);

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        cam_entry #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_entry (
            .clk     (clk),
            .rst_n   (rst_n),
            .we_i    (ent_we[i]),
            .clr_i   (ent_clr[i]),
            .wdata_i (bus.write_data_i),
            .key_i   (bus.search_data_i),
            .data_o  (ent_data[i]),
            .valid_o (ent_valid[i]),
            .match_o (ent_match[i])
        );
    end

    // Both encoders scan from the top down so the lowest qualifying index wins.
    always_comb begin
        free_found  = 1'b0;
        free_idx    = '0;
        match_found = 1'b0;
        match_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!ent_valid[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_WIDTH'(i);
            end
            if (ent_match[i]) begin
                match_found = 1'b1;
                match_idx   = IDX_WIDTH'(i);
            end
        end
    end

    always_comb begin
        ent_we  = '0;
        ent_clr = '0;
        count_d = count_q;
        case (cmd)
            CMD_WRITE: begin
                ent_we[bus.write_index_i] = 1'b1;
                if (!ent_valid[bus.write_index_i]) begin
                    count_d = count_q + OneCount;
                end
            end
            CMD_ALLOC: begin
                if (free_found) begin
                    ent_we[free_idx] = 1'b1;
                    count_d          = count_q + OneCount;
                end
            end
            CMD_INVAL: begin
                ent_clr[bus.inval_index_i] = 1'b1;
                if (ent_valid[bus.inval_index_i]) begin
                    count_d = count_q - OneCount;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        read_valid_d   = (cmd == CMD_READ);
        read_value_d   = '0;
        search_valid_d = (cmd == CMD_SEARCH);
        search_hit_d   = 1'b0;
        search_index_d = '0;
        alloc_index_d  = alloc_index_q;
        full_d         = (count_d == FullCount);
        error_d        = (n_cmds > 3'd1) || ((cmd == CMD_ALLOC) && !free_found);
        if ((cmd == CMD_READ) && ent_valid[bus.read_index_i]) begin
            read_value_d = ent_data[bus.read_index_i];
        end
        if ((cmd == CMD_SEARCH) && match_found) begin
            search_hit_d   = 1'b1;
            search_index_d = match_idx;
        end
        if ((cmd == CMD_ALLOC) && free_found) begin
            alloc_index_d = free_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            read_valid_q   <= 1'b0;
            read_value_q   <= '0;
            search_valid_q <= 1'b0;
            search_hit_q   <= 1'b0;
            search_index_q <= '0;
            alloc_index_q  <= '0;
            count_q        <= '0;
            full_q         <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            read_valid_q   <= read_valid_d;
            read_value_q   <= read_value_d;
            search_valid_q <= search_valid_d;
            search_hit_q   <= search_hit_d;
            search_index_q <= search_index_d;
            alloc_index_q  <= alloc_index_d;
            count_q        <= count_d;
            full_q         <= full_d;
            error_q        <= error_d;
        end
    end

    assign bus.read_valid_o   = read_valid_q;
    assign bus.read_value_o   = read_value_q;
    assign bus.search_valid_o = search_valid_q;
    assign bus.search_hit_o   = search_hit_q;
    assign bus.search_index_o = search_index_q;
    assign bus.alloc_index_o  = alloc_index_q;
    assign bus.count_o        = count_q;
    assign bus.full_o         = full_q;
    assign bus.error_o        = error_q;

endmodule
